// File: rtl/calc_pkg.sv
// Shared widths, types and FSM state encoding for the calculator sequencer.
package calc_pkg;

    localparam int unsigned CALC_OPCODE_W   = 14;
    localparam int unsigned CALC_RESULT_W   = 4;
    localparam int unsigned CALC_FIFO_DEPTH = 4;
    localparam int unsigned CALC_PTR_W      = 2;
    localparam int unsigned CALC_LEVEL_W    = 3;
    localparam int unsigned CALC_CNT_W      = 4;
    localparam int unsigned CALC_DONE_W     = 8;

    typedef logic [CALC_OPCODE_W-1:0] calc_opcode_t;
    typedef logic [CALC_RESULT_W-1:0] calc_result_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } calc_state_e;

endpackage

// File: rtl/calc_sequencer_if.sv
// Command / calculator / response bundle of the calculator sequencer.
// slave : the sequencer side (takes commands, drives calc_opcode, offers results)
// master: the parent side (offers commands, drives calc_z, consumes results)
interface calc_sequencer_if;
    import calc_pkg::*;

    logic                    cmd_valid;
    logic                    cmd_ready;
    calc_opcode_t            cmd_opcode;
    calc_opcode_t            calc_opcode;
    calc_result_t            calc_z;
    logic                    rsp_valid;
    logic                    rsp_ready;
    calc_result_t            rsp_z;
    logic [CALC_LEVEL_W-1:0] fifo_level;
    logic                    busy;
    logic [CALC_DONE_W-1:0]  done_count;

    modport slave (
        input  cmd_valid, cmd_opcode, calc_z, rsp_ready,
        output cmd_ready, calc_opcode, rsp_valid, rsp_z, fifo_level, busy, done_count
    );

    modport master (
        output cmd_valid, cmd_opcode, calc_z, rsp_ready,
        input  cmd_ready, calc_opcode, rsp_valid, rsp_z, fifo_level, busy, done_count
    );

endinterface

// File: rtl/calc_cmd_fifo.sv
// 4-entry show-ahead command FIFO.
// Ports: clk, rst_n; push_i/din_i write side; pop_i read side; head_o is the
// oldest entry; full_o, empty_o and level_o report occupancy.
module calc_cmd_fifo
    import calc_pkg::*;
#(
    parameter int unsigned DEPTH = CALC_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  calc_opcode_t            din_i,
    input  logic                    pop_i,
    output calc_opcode_t            head_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [CALC_LEVEL_W-1:0] level_o
);

    calc_opcode_t            mem_q [DEPTH];
    logic [CALC_PTR_W-1:0]   wr_ptr_q;
    logic [CALC_PTR_W-1:0]   rd_ptr_q;
    logic [CALC_LEVEL_W-1:0] level_q;
    logic                    push_ok;
    logic                    pop_ok;

    // A push into a full FIFO is dropped even when a pop happens alongside.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + CALC_PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + CALC_PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + CALC_LEVEL_W'(1);
                2'b01:   level_q <= level_q - CALC_LEVEL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset; the level qualifies every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (level_q == CALC_LEVEL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: queues opcodes, drives each to an external
// calculator for SETTLE_CYCLES cycles, captures the result and offers it
// on a valid/ready response port.
// Ports: clk, rst_n (async, active low); bus (calc_sequencer_if.slave)
// carrying the command, calculator and response signals plus status.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned FIFO_DEPTH    = CALC_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    calc_sequencer_if.slave      bus
);

    calc_state_e            state_q, state_d;
    logic [CALC_CNT_W-1:0]  cnt_q, cnt_d;
    calc_opcode_t           calc_opcode_q, calc_opcode_d;
    calc_result_t           rsp_z_q, rsp_z_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [CALC_DONE_W-1:0] done_q, done_d;

    logic                    issue;
    logic                    fifo_push;
    logic                    fifo_pop;
    calc_opcode_t            fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CALC_LEVEL_W-1:0] fifo_level;

    assign fifo_push = bus.cmd_valid & ~fifo_full;

    calc_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .din_i   (bus.cmd_opcode),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            calc_opcode_q <= '0;
            rsp_z_q       <= '0;
            rsp_valid_q   <= 1'b0;
            done_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            calc_opcode_q <= calc_opcode_d;
            rsp_z_q       <= rsp_z_d;
            rsp_valid_q   <= rsp_valid_d;
            done_q        <= done_d;
        end
    end

    // Next-state logic; issue loads the FIFO head from IDLE or straight out of RESP.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        calc_opcode_d = calc_opcode_q;
        rsp_z_d       = rsp_z_q;
        rsp_valid_d   = rsp_valid_q;
        done_d        = done_q;
        fifo_pop      = 1'b0;
        issue         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                issue = ~fifo_empty;
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CALC_CNT_W'(1);
                end else begin
                    rsp_z_d     = bus.calc_z;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    done_d      = done_q + CALC_DONE_W'(1);
                    issue       = ~fifo_empty;
                    if (fifo_empty) state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue) begin
            calc_opcode_d = fifo_head;
            fifo_pop      = 1'b1;
            cnt_d         = CALC_CNT_W'(SETTLE_CYCLES - 1);
            state_d       = ST_SETTLE;
        end
    end

    assign bus.cmd_ready   = ~fifo_full;
    assign bus.calc_opcode = calc_opcode_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_z       = rsp_z_q;
    assign bus.fifo_level  = fifo_level;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done_count  = done_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a calc_z = calc_opcode[3:0] stub.
module tb_calc_sequencer;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic glitch = 1'b0;

    always #5 clk = ~clk;

    calc_sequencer_if bus();

    assign bus.calc_z = glitch ? 4'hF : bus.calc_opcode[3:0];

    calc_sequencer #(
        .SETTLE_CYCLES (2),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_level"},      32'(bus.fifo_level),  0);
        check({tag, "_cmd_ready"},  32'(bus.cmd_ready),   1);
        check({tag, "_rsp_valid"},  32'(bus.rsp_valid),   0);
        check({tag, "_rsp_z"},      32'(bus.rsp_z),       0);
        check({tag, "_calc_op"},    32'(bus.calc_opcode), 0);
        check({tag, "_done"},       32'(bus.done_count),  0);
        check({tag, "_busy"},       32'(bus.busy),        0);
    endtask

    function automatic logic [13:0] bp_op(input int k);
        return 14'(32'h0A00 + k + 6);
    endfunction

    typedef struct {
        logic [13:0] op;
        logic [3:0]  exp_z;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [5];
    logic [13:0] ord_ops [4];
    logic [3:0]  zq [$];
    int          cq [$];
    int          exp_done;

    initial begin
        int  lat;
        int  k;
        int  stable_err;
        int  bad;
        int  pushed;
        int  resp;
        logic rdy_prev;
        logic seen;
        logic wrap_seen;
        logic [7:0] prev_done;

        vecs[0] = '{14'b01010000100000, 4'h0, 3};
        vecs[1] = '{14'h3FFF, 4'hF, 3};
        vecs[2] = '{14'h1235, 4'h5, 3};
        vecs[3] = '{14'h00A7, 4'h7, 3};
        vecs[4] = '{14'h2AC9, 4'h9, 3};
        ord_ops[0] = 14'h1231;
        ord_ops[1] = 14'h0452;
        ord_ops[2] = 14'h3FF3;
        ord_ops[3] = 14'h2004;

        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = '0;
        bus.rsp_ready  = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset_vals("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        exp_done = 0;

        // Single commands into an idle block
        foreach (vecs[i]) begin
            @(negedge clk);
            check("vec_ready", 32'(bus.cmd_ready), 1);
            bus.cmd_valid  = 1'b1;
            bus.cmd_opcode = vecs[i].op;
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            check("vec_no_early_rsp", 32'(bus.rsp_valid), 0);
            lat = 0;
            while (!bus.rsp_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check("vec_latency", 32'(lat), 32'(vecs[i].exp_lat));
            check("vec_rsp_z", 32'(bus.rsp_z), 32'(vecs[i].exp_z));
            check("vec_calc_op", 32'(bus.calc_opcode), 32'(vecs[i].op));
            exp_done++;
            @(negedge clk);
            check("vec_done", 32'(bus.done_count), 32'(exp_done % 256));
            check("vec_idle", 32'({bus.busy, bus.rsp_valid}), 0);
        end

        // Ordering and back-to-back spacing
        zq.delete();
        cq.delete();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                zq.push_back(bus.rsp_z);
                cq.push_back(c);
            end
            if (c < 4) begin
                bus.cmd_valid  = 1'b1;
                bus.cmd_opcode = ord_ops[c];
            end else begin
                bus.cmd_valid = 1'b0;
            end
        end
        check("ord_count", 32'(zq.size()), 4);
        for (int i = 0; i < 4 && i < zq.size(); i++) begin
            check("ord_z", 32'(zq[i]), 32'(i + 1));
            check("ord_cycle", 32'(cq[i]), 32'(4 + 3 * i));
        end
        exp_done += 4;
        check("ord_done", 32'(bus.done_count), 32'(exp_done % 256));

        // Backpressure: fill the FIFO behind a held response
        bus.rsp_ready = 1'b0;
        k = 0;
        rdy_prev = 1'b0;
        stable_err = 0;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.cmd_valid && rdy_prev) k++;
            if (seen && (!bus.rsp_valid || bus.rsp_z != 4'h6)) stable_err++;
            if (bus.rsp_valid) seen = 1'b1;
            rdy_prev = bus.cmd_ready;
            bus.cmd_valid  = (k < 6);
            bus.cmd_opcode = bp_op(k);
        end
        check("bp_accepted", 32'(k), 5);
        check("bp_level", 32'(bus.fifo_level), 4);
        check("bp_cmd_ready", 32'(bus.cmd_ready), 0);
        check("bp_rsp_valid", 32'(bus.rsp_valid), 1);
        check("bp_rsp_z", 32'(bus.rsp_z), 6);
        check("bp_calc_op_hold", 32'(bus.calc_opcode), 32'(bp_op(0)));
        check("bp_stable", 32'(stable_err), 0);

        // Drain; the pop out of a full FIFO must not admit the stalled push
        zq.delete();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.cmd_valid && rdy_prev) k++;
            if (bus.rsp_valid) zq.push_back(bus.rsp_z);
            if (c == 1) begin
                check("full_pop_level", 32'(bus.fifo_level), 3);
                check("full_pop_ready", 32'(bus.cmd_ready), 1);
            end
            rdy_prev = bus.cmd_ready;
            bus.cmd_valid = (k < 6);
            if (c == 0) bus.rsp_ready = 1'b1;
        end
        check("drain_count", 32'(zq.size()), 6);
        for (int i = 0; i < 6 && i < zq.size(); i++)
            check("drain_z", 32'(zq[i]), 32'(6 + i));
        exp_done += 6;
        check("drain_done", 32'(bus.done_count), 32'(exp_done % 256));

        // calc_z glitch while settling must not be captured
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = 14'h1B35;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1 glitch = 1'b1;
        @(negedge clk);
        check("glitch_busy", 32'(bus.busy), 1);
        @(negedge clk);
        glitch = 1'b0;
        @(negedge clk);
        check("glitch_rsp_valid", 32'(bus.rsp_valid), 1);
        check("glitch_rsp_z", 32'(bus.rsp_z), 5);
        exp_done++;
        @(negedge clk);

        // Reset while settling with three queued
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.cmd_valid  = 1'b1;
            bus.cmd_opcode = 14'(32'h0300 + i + 1);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("rst_pre_level", 32'(bus.fifo_level), 4);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rst_pre_settle", 32'({bus.busy, bus.rsp_valid}), 32'h2);
        check("rst_pre_level3", 32'(bus.fifo_level), 3);
        rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        exp_done = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.busy || bus.fifo_level != 0) bad++;
        end
        check("no_replay", 32'(bad), 0);

        // First accept on the first edge after release
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = 14'h0007;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("first_accept_level", 32'(bus.fifo_level), 1);
        bus.rsp_ready = 1'b1;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("first_accept_lat", 32'(lat), 3);
        check("first_accept_z", 32'(bus.rsp_z), 7);

        // done_count wrap over 256 completions from zero
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pushed = 0;
        resp = 0;
        rdy_prev = 1'b0;
        wrap_seen = 1'b0;
        prev_done = bus.done_count;
        for (int c = 0; c < 1200 && resp < 256; c++) begin
            @(negedge clk);
            if (bus.cmd_valid && rdy_prev) pushed++;
            if (bus.rsp_valid && bus.rsp_ready) resp++;
            if (prev_done == 8'd255 && bus.done_count == 8'd0) wrap_seen = 1'b1;
            prev_done = bus.done_count;
            rdy_prev = bus.cmd_ready;
            bus.cmd_valid  = (pushed < 256);
            bus.cmd_opcode = 14'(pushed);
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        if (prev_done == 8'd255 && bus.done_count == 8'd0) wrap_seen = 1'b1;
        check("wrap_resp_count", 32'(resp), 256);
        check("wrap_seen", 32'(wrap_seen), 1);
        check("wrap_done_zero", 32'(bus.done_count), 0);
        check("wrap_idle", 32'(bus.busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 Parameter SETTLE_CYCLES, default 2: the number of cycles calc_opcode is held before calc_z is sampled; legal range 1..15.
REQ-003 Parameter FIFO_DEPTH, default 4: command FIFO entries; the only legal value is 4.
REQ-004 Ports SHALL be:
  clk  in  1  clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  cmd_valid  in  1  command offered
  cmd_ready  out  1  command FIFO not full
  cmd_opcode  in  14  calculator opcode, treated as opaque
  calc_opcode  out  14  registered opcode driven to the calculator datapath
  calc_z  in  4  combinational calculator result
  rsp_valid  out  1  result available
  rsp_ready  in  1  result consumer ready
  rsp_z  out  4  captured result
  fifo_level  out  3  FIFO occupancy, 0..4
  busy  out  1  state is not IDLE
  done_count  out  8  completed responses, wraps 255->0

Function
REQ-005 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; cmd_ready = (fifo_level != 4).
REQ-006 A push and a pop in the same cycle SHALL both take effect, leaving fifo_level unchanged.
REQ-007 When the FIFO is full, no push SHALL occur even if a pop happens in the same cycle.
REQ-008 The FIFO SHALL preserve command order.
REQ-009 The FSM states SHALL be IDLE, SETTLE and RESP.
REQ-010 IDLE with FIFO non-empty: at the edge, calc_opcode <= FIFO head; pop; settle counter <= SETTLE_CYCLES-1; go to SETTLE.
REQ-011 SETTLE with counter > 0: decrement the counter.
REQ-012 SETTLE with counter = 0: at the edge, rsp_z <= calc_z; rsp_valid <= 1; go to RESP.
REQ-013 RESP: rsp_valid and rsp_z SHALL hold stable until a cycle in which rsp_ready = 1.
REQ-014 RESP with rsp_ready = 1: rsp_valid <= 0; done_count increments.
  - FIFO non-empty: load the next opcode and pop per REQ-010, with no IDLE cycle.
  - FIFO empty: go to IDLE.
REQ-015 Latency: a command accepted at edge E into an empty FIFO in IDLE SHALL have rsp_valid visible after edge E+1+SETTLE_CYCLES (E+3 at the default).
REQ-016 calc_opcode SHALL change only on a load per REQ-010; between loads it holds the last issued opcode.
REQ-017 calc_z SHALL be sampled only on the SETTLE-exit edge.
REQ-018 Back-to-back throughput with rsp_ready held 1: one response per SETTLE_CYCLES+1 cycles.
REQ-019 done_count SHALL wrap from 255 to 0 without any flag.
REQ-020 busy = (state != IDLE).

Reset
REQ-021 While rst_n = 0, regardless of clk:
  - state = IDLE, FIFO empty, fifo_level = 0
  - calc_opcode = 0, rsp_valid = 0, rsp_z = 0
  - done_count = 0, busy = 0, cmd_ready = 1
REQ-022 Reset asserted mid-operation SHALL discard all queued commands and any pending response; nothing is replayed after release.
REQ-023 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-024 Package calc_pkg SHALL hold:
  - CALC_OPCODE_W = 14, CALC_RESULT_W = 4, CALC_FIFO_DEPTH = 4
  - the FSM state enumeration
REQ-025 The FIFO SHALL be a sub-module, calc_cmd_fifo: 4x14 storage, 2-bit pointers, 3-bit level, push/pop/full/empty.
REQ-026 The calculator datapath SHALL sit outside this block; the parent connects calc_opcode and calc_z.

Verification
REQ-027 The bench stub SHALL drive calc_z = calc_opcode[3:0].
REQ-028 Single command: push 14'b01010000100000 into an idle block, rsp_ready=1 -> rsp_valid rises 3 edges after accept, rsp_z=4'b0000, done_count=1.
REQ-029 Ordering: push opcodes with low nibbles 1, 2, 3, 4 back-to-back with rsp_ready=1 -> rsp_z sequence 1, 2, 3, 4; responses spaced 3 cycles apart.
REQ-030 Full/backpressure: rsp_ready=0; offer 6 commands -> 1 issued + 4 queued, then cmd_ready=0, fifo_level=4; the 6th is stalled; rsp_valid and rsp_z hold stable.
REQ-031 Settle sampling: the stub glitches calc_z to 4'hF during the first SETTLE cycle -> the captured rsp_z equals the final stub value, not 4'hF.
REQ-032 Reset mid-operation: assert rst_n=0 in SETTLE with 3 queued -> outputs match REQ-021 immediately; no rsp_valid after release until a new push.
REQ-033 Wrap: complete 256 commands -> done_count returns to 0.
